// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction RAM wrapper.
package imem_loader_pkg;

  // Loader session states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  // Instruction word geometry
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = 8 * WORD_BYTES;

  // Address and word-count widths
  localparam int ADDR_W = 64;
  localparam int CNT_W  = 16;

  // Byte address of instruction word number idx, counted from base
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    logic [ADDR_W-1:0] offset;
    offset = {{(ADDR_W-CNT_W-2){1'b0}}, idx, 2'b00};
    return base + offset;
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four stream bytes, LSB first, into one 32-bit instruction word.
// word_complete is combinational with the 4th accepted byte so the caller
// can register the write on the same edge that accepts that byte.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_complete
);

  logic [1:0]  idx_q;
  logic [23:0] lanes_q;

  // Byte-lane index: restarts on reset or clear, advances per accepted byte
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx_q <= 2'd0;
    end else if (byte_en) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // Lower three lanes are stored; the top lane is taken straight from the stream
  always_ff @(posedge clk) begin
    if (byte_en) begin
      case (idx_q)
        2'd0:    lanes_q[7:0]   <= byte_in;
        2'd1:    lanes_q[15:8]  <= byte_in;
        2'd2:    lanes_q[23:16] <= byte_in;
        default: lanes_q        <= lanes_q;
      endcase
    end
  end

  assign word          = {byte_in, lanes_q};
  assign word_complete = byte_en && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a count-prefixed byte stream, writes
// little-endian 32-bit words into instruction RAM and holds the CPU in reset
// until the whole program has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int               MemSize  = 40,
  parameter logic [ADDR_W-1:0] BaseAddr = 64'h0
)(
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [WORD_W-1:0] WrData,
  output logic              CpuHold,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [CNT_W-1:0] MEM_WORDS = CNT_W'(MemSize);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  n_full;
  logic [CNT_W-1:0]  word_cnt_q;
  logic              byte_acc;
  logic              ready;
  logic              busy;
  logic              done;
  logic              err;
  logic              hold;

  logic              asm_clear;
  logic              asm_en;
  logic [WORD_W-1:0] asm_word;
  logic              asm_complete;

  logic              wr_en_p1;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [WORD_W-1:0] wr_data_p1;

  assign byte_acc  = ByteValid && ready;
  assign n_full    = {ByteIn, n_q[7:0]};
  assign asm_clear = (state_q != ST_DATA);
  assign asm_en    = byte_acc && (state_q == ST_DATA);

  imem_word_assembler u_asm (
    .clk           (CLK),
    .rst           (Reset),
    .clear         (asm_clear),
    .byte_en       (asm_en),
    .byte_in       (ByteIn),
    .word          (asm_word),
    .word_complete (asm_complete)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and state-derived status outputs
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    hold    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_CNT_LO;
      end
      ST_CNT_LO: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (byte_acc) state_d = ST_CNT_HI;
      end
      ST_CNT_HI: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (byte_acc) begin
          if (n_full == '0)            state_d = ST_DONE;
          else if (n_full > MEM_WORDS) state_d = ST_ERROR;
          else                         state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        ready = 1'b1;
        busy  = 1'b1;
        // The last write is in flight this cycle; finish together with it
        if (wr_en_p1 && ((word_cnt_q + 16'd1) == n_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        hold = 1'b0;
        if (Start) state_d = ST_CNT_LO;
      end
      ST_ERROR: begin
        err = 1'b1;
        if (Start) state_d = ST_CNT_LO;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Word count capture from the header and written-word counter
  always_ff @(posedge CLK) begin
    if (Reset) begin
      n_q        <= '0;
      word_cnt_q <= '0;
    end else begin
      if (byte_acc && (state_q == ST_CNT_LO)) begin
        n_q[7:0] <= ByteIn;
      end
      if (byte_acc && (state_q == ST_CNT_HI)) begin
        n_q[15:8]  <= ByteIn;
        word_cnt_q <= '0;
      end else if (wr_en_p1) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
    end
  end

  // ---- stage p1: registered RAM write, overlapping the next byte ----
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= BaseAddr;
      wr_data_p1 <= '0;
    end else begin
      wr_en_p1 <= asm_complete;
      if (asm_complete) begin
        wr_addr_p1 <= word_addr(BaseAddr, word_cnt_q);
        wr_data_p1 <= asm_word;
      end
    end
  end

  assign ByteReady = ready;
  assign Busy      = busy;
  assign Done      = done;
  assign Error     = err;
  assign CpuHold   = hold;
  assign WrEn      = wr_en_p1;
  assign WrAddr    = wr_addr_p1;
  assign WrData    = wr_data_p1;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, word assembly, write
// timing, size rejection, gapped streams and mid-session reset.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WrEn;
  logic [63:0] WrAddr;
  logic [31:0] WrData;
  logic        CpuHold;
  logic        Busy;
  logic        Done;
  logic        Error;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Write log filled by the monitor; the stimulus only reads it
  int          wr_total = 0;
  logic [63:0] wr_addr_log [16];
  logic [31:0] wr_data_log [16];
  int          wr_cyc_log  [16];

  imem_loader #(.MemSize(40), .BaseAddr(64'h0)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Start     (Start),
    .ByteIn    (ByteIn),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .CpuHold   (CpuHold),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (WrEn && wr_total < 16) begin
      wr_addr_log[wr_total] = WrAddr;
      wr_data_log[wr_total] = WrData;
      wr_cyc_log[wr_total]  = cyc;
      wr_total = wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests = tests + 1;
    if (obs !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ByteIn    = b;
    ByteValid = 1'b1;
    tick();
    ByteValid = 1'b0;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hold"},  64'(CpuHold),   64'd1);
    chk({tag, "_ready"}, 64'(ByteReady), 64'd0);
    chk({tag, "_wren"},  64'(WrEn),      64'd0);
    chk({tag, "_addr"},  WrAddr,         64'h0);
    chk({tag, "_data"},  64'(WrData),    64'h0);
    chk({tag, "_busy"},  64'(Busy),      64'd0);
    chk({tag, "_done"},  64'(Done),      64'd0);
    chk({tag, "_err"},   64'(Error),     64'd0);
  endtask

  logic [7:0] two_word [10];
  logic [7:0] gap_word [4];
  int base;

  initial begin
    two_word = '{8'h02, 8'h00, 8'hE9, 8'h03, 8'h40, 8'hF8, 8'hEA, 8'h83, 8'h40, 8'hF8};
    gap_word = '{8'h4A, 8'h01, 8'h0B, 8'hAA};

    Reset = 1'b1; Start = 1'b0; ByteIn = 8'h00; ByteValid = 1'b0;
    tick();
    tick();
    chk_reset_outputs("rst");
    Reset = 1'b0;
    tick();

    // Two-word load at full rate
    base = wr_total;
    pulse_start();
    chk("cntlo_ready", 64'(ByteReady), 64'd1);
    chk("cntlo_busy",  64'(Busy),      64'd1);
    for (int i = 0; i < 10; i++) begin
      ByteIn    = two_word[i];
      ByteValid = 1'b1;
      tick();
    end
    ByteValid = 1'b0;
    chk("w1_wren",      64'(WrEn),   64'd1);
    chk("w1_addr",      WrAddr,      64'h4);
    chk("w1_data",      64'(WrData), 64'hF84083EA);
    chk("w1_done_early",64'(Done),   64'd0);
    tick();
    chk("load_done",   64'(Done),    64'd1);
    chk("load_hold",   64'(CpuHold), 64'd0);
    chk("load_busy",   64'(Busy),    64'd0);
    chk("load_wren",   64'(WrEn),    64'd0);
    chk("load_addr_hold", WrAddr,    64'h4);
    chk("load_nwr",    64'(wr_total - base), 64'd2);
    chk("w0_addr",     wr_addr_log[base],        64'h0);
    chk("w0_data",     64'(wr_data_log[base]),   64'hF84003E9);
    chk("w_spacing",   64'(wr_cyc_log[base+1] - wr_cyc_log[base]), 64'd4);

    // Zero-length load
    base = wr_total;
    pulse_start();
    chk("zero_done_clr", 64'(Done), 64'd0);
    send(8'h00);
    send(8'h00);
    chk("zero_done", 64'(Done), 64'd1);
    chk("zero_busy", 64'(Busy), 64'd0);
    tick();
    chk("zero_nwr", 64'(wr_total - base), 64'd0);

    // Oversize count (41 words) is rejected
    base = wr_total;
    pulse_start();
    send(8'h29);
    send(8'h00);
    chk("over_err",   64'(Error),     64'd1);
    chk("over_hold",  64'(CpuHold),   64'd1);
    chk("over_busy",  64'(Busy),      64'd0);
    chk("over_ready", 64'(ByteReady), 64'd0);
    tick();
    tick();
    chk("over_nwr", 64'(wr_total - base), 64'd0);
    pulse_start();
    chk("over_err_clr", 64'(Error), 64'd0);
    chk("over_restart", 64'(Busy),  64'd1);

    // Exactly MemSize words is accepted
    send(8'h28);
    send(8'h00);
    chk("max_err",  64'(Error), 64'd0);
    chk("max_busy", 64'(Busy),  64'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("max_rst_busy", 64'(Busy), 64'd0);

    // Bytes offered while idle must not be consumed
    ByteIn    = 8'h07;
    ByteValid = 1'b1;
    tick();
    tick();
    ByteValid = 1'b0;

    // Gapped stream with ignored Start pulses during DATA
    base = wr_total;
    pulse_start();
    send(8'h01);
    send(8'h00);
    for (int i = 0; i < 4; i++) begin
      send(gap_word[i]);
      ByteIn = 8'hFF;
      Start  = 1'b1;
      tick();
      Start  = 1'b0;
      tick();
    end
    chk("gap_done", 64'(Done), 64'd1);
    chk("gap_nwr",  64'(wr_total - base), 64'd1);
    chk("gap_addr", wr_addr_log[base],       64'h0);
    chk("gap_data", 64'(wr_data_log[base]),  64'hAA0B014A);

    // Reset after two of four data bytes
    base = wr_total;
    pulse_start();
    send(8'h01);
    send(8'h00);
    send(8'h11);
    send(8'h22);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_reset_outputs("midrst");
    tick();
    chk("midrst_nwr", 64'(wr_total - base), 64'd0);

    // A fresh session after the reset assembles a clean word
    base = wr_total;
    pulse_start();
    send(8'h01);
    send(8'h00);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    send(8'hEF);
    tick();
    chk("post_done", 64'(Done), 64'd1);
    chk("post_nwr",  64'(wr_total - base), 64'd1);
    chk("post_addr", wr_addr_log[base],      64'h0);
    chk("post_data", 64'(wr_data_log[base]), 64'hEFBEADDE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface. It receives a byte stream from a host link and assembles 32-bit little-endian instruction words. It writes them into a writable instruction RAM at byte addresses 0x000, 0x004, and so on, in the same 64-bit byte-address space the processor fetches from. While loading it holds the processor in reset, then releases it once the whole program is written.

Parameters:
MemSize, 40, instruction RAM capacity in 32-bit words; larger programs are rejected
BaseAddr, 64'h0, byte address of the first word written

Ports:
CLK  input  1  clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle pulse; begins a load session (ignored unless idle/done/error)
ByteIn  input  8  stream byte
ByteValid  input  1  ByteIn valid this cycle
ByteReady  output  1  loader accepts ByteIn this cycle; a byte transfers when ByteValid&&ByteReady
WrEn  output  1  one-cycle instruction-RAM write strobe
WrAddr  output  64  byte address for the write (word aligned)
WrData  output  32  instruction word for the write
CpuHold  output  1  holds the processor in reset while high
Busy  output  1  session in progress
Done  output  1  last session completed successfully (sticky until next Start/Reset)
Error  output  1  last session rejected (sticky until next Start/Reset)

Behaviour:
- Reset values: ByteReady=0, WrEn=0, WrAddr=BaseAddr, WrData=0, CpuHold=1, Busy=0, Done=0, Error=0; FSM in IDLE.
- CpuHold is 1 in IDLE, CNT_LO, CNT_HI and DATA; it is 0 only in DONE. In ERROR, CpuHold stays 1.
- Stream format: 2-byte word count N, low byte first. Then N words of 4 bytes each, LSB first.
- States:
  - IDLE: on Start, go to CNT_LO.
  - CNT_LO: store the accepted byte as N[7:0]; go to CNT_HI.
  - CNT_HI: store the accepted byte as N[15:8].
    - If N==0, go to DONE.
    - If N>MemSize, go to ERROR.
    - Otherwise clear the byte index and word counter and go to DATA.
  - DATA: shift each accepted byte into the word buffer at lane = byte index (0..3).
    - On the 4th byte, next cycle: WrEn=1, WrData=assembled word, WrAddr=BaseAddr+4*word counter; the word counter then increments.
    - When the word counter reaches N after that write, go to DONE.
  - DONE: Done=1, Busy=0. On Start, go to CNT_LO with Done cleared.
  - ERROR: Error=1, Busy=0. On Start, go to CNT_LO with Error cleared.
- ByteReady=1 in CNT_LO, CNT_HI and DATA, and 0 elsewhere. It is asserted every cycle in those states; there are no bubbles, because the write is registered and overlaps the next byte's acceptance.
- Bytes presented while ByteReady=0 are not consumed.
- Busy=1 in CNT_LO, CNT_HI and DATA.
- Latency: WrEn pulses exactly 1 cycle after the 4th byte of a word is accepted. Back-to-back full-rate streaming gives one write every 4 cycles.
- WrAddr and WrData hold their last values when WrEn=0.
- The final write of a session and the transition to DONE occur in the same cycle, so Done=1 in the cycle after the last WrEn.
- Start in CNT_LO/CNT_HI/DATA is ignored; the session is not restarted.
- Reset mid-session: immediate return to IDLE with reset values. Any partially written RAM contents are left as they are; no write is issued for the partial word.
- Address arithmetic is 64-bit; the word counter is 16 bits wide. MemSize bounds N, so no address wrap can occur.

Decomposition:
- Shared package/header: state encodings (IDLE, CNT_LO, CNT_HI, DATA, DONE, ERROR) and a WORD_BYTES=4 constant. The same package is included by the instruction RAM wrapper.
- One natural sub-module: imem_word_assembler, a byte-lane shift register with a 2-bit index that outputs the word plus a word_complete pulse.
- The FSM and address generation stay in imem_loader.

Test Plan:
- Reset then idle: hold Reset 2 cycles -> CpuHold=1, ByteReady=0, WrEn=0, Done=0, Error=0.
- Two-word load at full rate: Start, bytes 02 00 E9 03 40 F8 EA 83 40 F8 ->
  - WrEn at addr 0x0 with 32'hF84003E9,
  - then WrEn at addr 0x4 with 32'hF84083EA, 4 cycles apart,
  - then Done=1 and CpuHold=0 the cycle after the last write.
- Zero-length load: Start, bytes 00 00 -> no WrEn, Done=1 one cycle after the 2nd byte.
- Oversize: Start, count 29 00 (41 > 40) -> Error=1, CpuHold=1, no WrEn; a new Start then clears Error.
- Gapped stream: ByteValid toggled 1-0-0-1 between bytes of word AA0B014A -> a single WrEn with 32'hAA0B014A at addr 0x0. Start pulses during DATA are ignored.
- Reset mid-word: Reset after 2 of the 4 data bytes -> no WrEn, FSM in IDLE, all outputs at reset values.
